// File: rtl/acc_sequencer.sv
// acc_sequencer: runs one accumulator job: clear, accept tile beats, drain, write, done.
// Define ACC_SEQ_PERF_EN to add the perf_stall bubble counter output.
module acc_sequencer #(
  parameter int unsigned ARR_SIZE  = 4,
  parameter int unsigned DRAIN_CYC = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_tiles,
  input  logic [3:0]       base_addr,
  input  logic             abort,
  input  logic             tile_valid,
  output logic             tile_ready,
  output logic             acc_reset,
  output logic             store_output,
  output logic [3:0]       op_buffer_address,
  output logic             busy,
  output logic             done
`ifdef ACC_SEQ_PERF_EN
  ,
  output logic [15:0]      perf_stall
`endif
);

  localparam int unsigned DW = 4;
  localparam int unsigned AW = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ACCUM,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  if (ARR_SIZE == 0 || DRAIN_CYC == 0 || DRAIN_CYC > 15) begin : g_bad_param
    $error("acc_sequencer: ARR_SIZE must be >0 and DRAIN_CYC within 1..15");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, tiles_q, tiles_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic [AW-1:0]    addr_d;
  logic             job_start, abort_hit;
  logic             store_q, store_d;
  logic             tile_ready_d, acc_reset_d, busy_d, done_d;

  // Next state, counters and registered-output decode from the next state
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tiles_d   = tiles_q;
    drain_d   = drain_q;
    addr_d    = op_buffer_address;
    abort_hit = 1'b0;
    job_start = (state_q == S_IDLE) && start && !abort;

    case (state_q)
      S_IDLE: begin
        if (job_start) begin
          tiles_d = num_tiles;
          cnt_d   = '0;
          if (num_tiles == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_CLEAR;
            addr_d  = base_addr;
          end
        end
      end
      S_CLEAR: state_d = S_ACCUM;
      S_ACCUM: begin
        if (tile_valid && tile_ready) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == tiles_q) begin
            state_d = S_DRAIN;
            drain_d = DW'(DRAIN_CYC - 1);
          end
        end
      end
      S_DRAIN: begin
        if (drain_q == '0) state_d = S_WRITE;
        else               drain_d = drain_q - DW'(1);
      end
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (abort && (state_q != S_IDLE)) begin
      state_d   = S_IDLE;
      abort_hit = 1'b1;
      cnt_d     = '0;
      drain_d   = '0;
    end

    tile_ready_d = (state_d == S_ACCUM);
    acc_reset_d  = (state_d == S_CLEAR) || abort_hit;
    store_d      = (state_d == S_DRAIN) || (state_d == S_WRITE);
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q           <= S_IDLE;
      cnt_q             <= '0;
      tiles_q           <= '0;
      drain_q           <= '0;
      op_buffer_address <= '0;
      tile_ready        <= 1'b0;
      acc_reset         <= 1'b0;
      store_q           <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      tiles_q           <= tiles_d;
      drain_q           <= drain_d;
      op_buffer_address <= addr_d;
      tile_ready        <= tile_ready_d;
      acc_reset         <= acc_reset_d;
      store_q           <= store_d;
      busy              <= busy_d;
      done              <= done_d;
    end
  end

  // An accepted beat strobes the accumulator in its own cycle; drain/write strobes come from store_q
  assign store_output = store_q | (tile_ready & tile_valid);

`ifdef ACC_SEQ_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall <= '0;
    end else if (job_start) begin
      perf_stall <= '0;
    end else if ((state_q == S_ACCUM) && !tile_valid && (perf_stall != 16'hFFFF)) begin
      perf_stall <= perf_stall + 16'(1);
    end
  end
`endif

endmodule

// File: tb/tb_acc_sequencer.sv
// Self-checking bench for acc_sequencer: directed scenarios plus randomized jobs
// checked cycle by cycle against an expected phase timeline built per job.
`timescale 1ns/1ps
module tb_acc_sequencer;

  localparam int unsigned CNT_W     = 8;
  localparam int unsigned DRAIN_CYC = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] num_tiles;
  logic [3:0]       base_addr;
  logic             abort;
  logic             tile_valid;
  logic             tile_ready;
  logic             acc_reset;
  logic             store_output;
  logic [3:0]       op_buffer_address;
  logic             busy;
  logic             done;
`ifdef ACC_SEQ_PERF_EN
  logic [15:0]      perf_stall;
`endif

  int errors = 0;
  int checks = 0;
  logic [3:0] exp_addr;
  int done_idx;
  int store_cnt;
  int stall_cnt;

  typedef struct packed {
    logic       ready;
    logic       ar;
    logic       st;
    logic       bsy;
    logic       dn;
    logic [3:0] addr;
  } obs_t;

  always #5 clk = ~clk;

  acc_sequencer #(
    .ARR_SIZE (4),
    .DRAIN_CYC(DRAIN_CYC),
    .CNT_W    (CNT_W)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .num_tiles        (num_tiles),
    .base_addr        (base_addr),
    .abort            (abort),
    .tile_valid       (tile_valid),
    .tile_ready       (tile_ready),
    .acc_reset        (acc_reset),
    .store_output     (store_output),
    .op_buffer_address(op_buffer_address),
    .busy             (busy),
    .done             (done)
`ifdef ACC_SEQ_PERF_EN
    ,
    .perf_stall       (perf_stall)
`endif
  );

  function automatic obs_t mk(input logic r, input logic a, input logic s,
                              input logic b, input logic d, input logic [3:0] ad);
    return {r, a, s, b, d, ad};
  endfunction

  function automatic obs_t observe();
    return {tile_ready, acc_reset, store_output, busy, done, op_buffer_address};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, want);
    end
  endtask

  // mode 0: tile_valid always 1; mode 1: random; mode 2: pat bits LSB first, then 1s
  task automatic run_job(input int n, input logic [3:0] b, input int mode,
                         input logic [31:0] pat, input int abort_in, input int rst_at,
                         input string tag);
    obs_t e[$];
    logic v_q[$];
    logic [3:0] ja;
    int acc;
    int pi;
    int abort_at;
    logic v;
    obs_t got;

    ja = (n == 0) ? exp_addr : b;
    e.push_back(mk(0, 0, 0, 0, 0, exp_addr));
    v_q.push_back(1'($urandom_range(0, 1)));
    if (n == 0) begin
      e.push_back(mk(0, 0, 0, 1, 1, ja));
      v_q.push_back(1'($urandom_range(0, 1)));
    end else begin
      e.push_back(mk(0, 1, 0, 1, 0, ja));
      v_q.push_back(1'($urandom_range(0, 1)));
      acc = 0;
      pi  = 0;
      while (acc < n) begin
        case (mode)
          0:       v = 1'b1;
          1:       v = ($urandom_range(0, 3) != 0);
          default: v = (pi < 32) ? pat[pi] : 1'b1;
        endcase
        e.push_back(mk(1, 0, v, 1, 0, ja));
        v_q.push_back(v);
        acc += int'(v);
        pi++;
      end
      for (int k = 0; k < int'(DRAIN_CYC); k++) begin
        e.push_back(mk(0, 0, 1, 1, 0, ja));
        v_q.push_back(1'($urandom_range(0, 1)));
      end
      e.push_back(mk(0, 0, 1, 1, 0, ja));
      v_q.push_back(1'($urandom_range(0, 1)));
      e.push_back(mk(0, 0, 0, 1, 1, ja));
      v_q.push_back(1'($urandom_range(0, 1)));
    end
    e.push_back(mk(0, 0, 0, 0, 0, ja));
    v_q.push_back(1'($urandom_range(0, 1)));

    abort_at = (abort_in >= 1 && abort_in < e.size() - 1) ? abort_in : -1;
    if (abort_at > 0) begin
      while (e.size() > abort_at + 1) begin
        void'(e.pop_back());
        void'(v_q.pop_back());
      end
      e.push_back(mk(0, 1, 0, 0, 0, ja));
      v_q.push_back(1'($urandom_range(0, 1)));
      e.push_back(mk(0, 0, 0, 0, 0, ja));
      v_q.push_back(1'($urandom_range(0, 1)));
    end

    done_idx  = -1;
    store_cnt = 0;
    stall_cnt = 0;
    foreach (e[i]) begin
      @(negedge clk);
      start      = (i == 0) ? 1'b1 : (e[i].bsy ? 1'($urandom_range(0, 1)) : 1'b0);
      abort      = (i == abort_at);
      tile_valid = v_q[i];
      num_tiles  = (i == 0) ? CNT_W'(n) : CNT_W'($urandom);
      base_addr  = (i == 0) ? b : 4'($urandom);
      #1;
      got = observe();
      check($sformatf("%s cyc%0d", tag, i), 32'(got), 32'(e[i]));
      if (got.dn && done_idx < 0) done_idx = i;
      if (got.st) store_cnt++;
      if (e[i].ready && !v_q[i]) stall_cnt++;
      if (i == rst_at) begin
        #2 rst = 1'b0;
        #1;
        check($sformatf("%s async_rst", tag), 32'(observe()), 32'(0));
        exp_addr = 4'h0;
        break;
      end
    end
    if (rst_at < 0) exp_addr = ja;
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    int n;
    int ab;
    rst        = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    tile_valid = 1'b0;
    num_tiles  = '0;
    base_addr  = '0;
    exp_addr   = 4'h0;

    #12;
    check("reset_state", 32'(observe()), 32'(0));
    @(negedge clk);
    rst = 1'b1;

    // Straight job: 3 beats, constant valid
    run_job(3, 4'd5, 0, 32'h0, -1, -1, "basic");
    check("basic_done_latency", 32'(done_idx), 32'(10));
    check("basic_store_cycles", 32'(store_cnt), 32'(3 + DRAIN_CYC + 1));
    check("basic_final_addr", 32'(op_buffer_address), 32'(5));

    // Bubbles: valid pattern 1,0,1,0,1,1
    run_job(4, 4'hA, 2, 32'b110101, -1, -1, "bubbles");
    check("bubbles_store_cycles", 32'(store_cnt), 32'(4 + DRAIN_CYC + 1));
    check("bubbles_stalls", 32'(stall_cnt), 32'(2));
`ifdef ACC_SEQ_PERF_EN
    check("bubbles_perf_stall", 32'(perf_stall), 32'(2));
`endif

    // Empty job
    run_job(0, 4'h3, 0, 32'h0, -1, -1, "empty");
    check("empty_done_latency", 32'(done_idx), 32'(1));
    check("empty_no_store", 32'(store_cnt), 32'(0));
`ifdef ACC_SEQ_PERF_EN
    check("empty_perf_stall", 32'(perf_stall), 32'(0));
`endif

    // Abort during the second ACCUM beat
    run_job(3, 4'h6, 0, 32'h0, 3, -1, "abort");
    check("abort_no_done", 32'(done_idx), 32'hFFFF_FFFF);

    // start and abort together in IDLE
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      start      = 1'b1;
      abort      = 1'b1;
      tile_valid = 1'b1;
      num_tiles  = CNT_W'(5);
      base_addr  = 4'h7;
      #1;
      check("start_abort_idle", 32'(observe()), 32'(mk(0, 0, 0, 0, 0, exp_addr)));
    end
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    #1;
    check("after_start_abort", 32'(observe()), 32'(mk(0, 0, 0, 0, 0, exp_addr)));

    // Async reset in the second DRAIN cycle, then a fresh job right after release
    run_job(3, 4'h4, 0, 32'h0, -1, 6, "rst_drain");
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      check("rst_hold", 32'(observe()), 32'(0));
    end
    @(posedge clk);
    #2 rst = 1'b1;
    run_job(3, 4'd9, 0, 32'h0, -1, -1, "after_rst");
    check("after_rst_done_latency", 32'(done_idx), 32'(10));
    check("after_rst_addr", 32'(op_buffer_address), 32'(9));

    // Largest tile count
    run_job(255, 4'hC, 0, 32'h0, -1, -1, "max_tiles");
    check("max_tiles_store_cycles", 32'(store_cnt), 32'(255 + DRAIN_CYC + 1));
    check("max_tiles_done", 32'(done_idx), 32'(255 + DRAIN_CYC + 3));

    // Randomized jobs, some aborted
    for (int j = 0; j < 25; j++) begin
      n  = $urandom_range(0, 12);
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, n + 8) : -1;
      run_job(n, 4'($urandom), 1, 32'h0, ab, -1, $sformatf("rand%0d", j));
`ifdef ACC_SEQ_PERF_EN
      check($sformatf("rand%0d perf_stall", j), 32'(perf_stall), 32'(stall_cnt));
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
